// File: rtl/shl_op.sv
// shl_op: shift-left / add functional unit for HLS datapaths.
// Combinational shift (out) and add (sum, cout) are always available.
// A one-stage registered path captures either result on request.
module shl_op #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] res_q,
  output logic             carry_q,
  output logic             valid_q
);

  // Width of a shift amount that can address every bit position.
  localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // WIDTH expressed at operand width, so the out-of-range test needs no
  // widening of in1.
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  // Registered-path operation select.
  typedef enum logic {
    OP_SHL = 1'b0,
    OP_ADD = 1'b1
  } op_e;

  // Reject unsupported widths at elaboration time.
  if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
    $error("shl_op: WIDTH must be in 2..64");
  end

  logic             shift_oob;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  op_e              op_sel;

  assign op_sel = op_e'(op);

  // Shift: every bit of in1 matters, so any amount >= WIDTH clears the
  // result instead of wrapping modulo WIDTH.
  always_comb begin
    shift_oob = (in1 >= WIDTH_V);
    shamt     = in1[SHW-1:0];
    out       = shift_oob ? '0 : (in0 << shamt);
  end

  // Add: one bit wider than the operands so the carry falls out directly.
  always_comb begin
    add_full = {1'b0, in0} + {1'b0, in1};
    sum      = add_full[WIDTH-1:0];
    cout     = add_full[WIDTH];
  end

  // Registered result: capture on in_valid, hold otherwise; valid_q pulses
  // for one cycle per capture. Reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      valid_q <= in_valid;
      if (in_valid) begin
        if (op_sel == OP_ADD) begin
          res_q   <= sum;
          carry_q <= cout;
        end else begin
          res_q   <= out;
          carry_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_shl_op.sv
// tb_shl_op: self-checking bench for shl_op (WIDTH=32 and WIDTH=8).
// Registered results are checked through a scoreboard queue.
module tb_shl_op;

  logic        clk;
  logic        rst;
  logic [31:0] in0, in1;
  logic [31:0] out, sum;
  logic        cout;
  logic        op, in_valid;
  logic [31:0] res_q;
  logic        carry_q, valid_q;

  logic [7:0]  a8, b8, out8, sum8, res8;
  logic        cout8, carry8, valid8;

  typedef struct {
    logic [31:0] res;
    logic        carry;
  } exp_t;

  exp_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;

  shl_op #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(out), .sum(sum),
    .cout(cout), .op(op), .in_valid(in_valid), .res_q(res_q),
    .carry_q(carry_q), .valid_q(valid_q)
  );

  shl_op #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in0(a8), .in1(b8), .out(out8), .sum(sum8),
    .cout(cout8), .op(1'b0), .in_valid(1'b0), .res_q(res8),
    .carry_q(carry8), .valid_q(valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic c);
    exp_t e;
    e.res   = r;
    e.carry = c;
    sb.push_back(e);
  endtask

  // Scoreboard: every valid_q pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (rst && valid_q) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(valid_q), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_q", 64'(res_q), 64'(e.res));
        check("carry_q", 64'(carry_q), 64'(e.carry));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1, exp_out;
    logic [63:0] wide;

    rst = 1'b0; op = 1'b0; in_valid = 1'b0;
    in0 = 32'd5; in1 = 32'd2; a8 = '0; b8 = '0;
    #1;
    // Reset state and combinational output during reset.
    check("rst_res_q", 64'(res_q), 64'd0);
    check("rst_carry_q", 64'(carry_q), 64'd0);
    check("rst_valid_q", 64'(valid_q), 64'd0);
    check("shl_5_2_in_rst", 64'(out), 64'd20);
    #11;
    rst = 1'b1;

    // Shift sweep and boundaries.
    in0 = 32'h8000_0001; in1 = 32'd1; #1;
    check("shl_msb_drop", 64'(out), 64'h2);
    in0 = 32'h1234_5678; in1 = 32'd0; #1;
    check("shl_zero", 64'(out), 64'h1234_5678);
    in0 = 32'hFFFF_FFFF; in1 = 32'd31; #1;
    check("shl_31", 64'(out), 64'h8000_0000);
    in1 = 32'd32; #1;
    check("shl_32", 64'(out), 64'd0);
    in1 = 32'h0000_0100; #1;
    check("shl_256", 64'(out), 64'd0);
    in1 = 32'h8000_0001; #1;
    check("shl_huge", 64'(out), 64'd0);

    // Add wrap.
    in0 = 32'hFFFF_FFFF; in1 = 32'd1; #1;
    check("add_wrap_sum", 64'(sum), 64'd0);
    check("add_wrap_cout", 64'(cout), 64'd1);
    in0 = 32'd7; in1 = 32'd8; #1;
    check("add_sum", 64'(sum), 64'd15);
    check("add_cout", 64'(cout), 64'd0);

    // Random combinational vectors against an independent model.
    for (int i = 0; i < 20; i++) begin
      r0 = $urandom();
      r1 = (i % 4 == 0) ? $urandom() : 32'($urandom_range(0, 40));
      in0 = r0; in1 = r1; #1;
      exp_out = 32'd0;
      if (r1 < 32) begin
        wide = 64'(r0) * (64'd1 << r1);
        exp_out = wide[31:0];
      end
      check("rand_shl", 64'(out), 64'(exp_out));
      wide = 64'(r0) + 64'(r1);
      check("rand_sum", 64'(sum), 64'(wide[31:0]));
      check("rand_cout", 64'(cout), 64'(wide[32]));
    end

    // Registered path, three back-to-back captures.
    tick();
    op = 1'b0; in0 = 32'd3; in1 = 32'd4; in_valid = 1'b1; push(32'd48, 1'b0);
    tick();
    op = 1'b1; in0 = 32'd10; in1 = 32'd20; push(32'd30, 1'b0);
    tick();
    op = 1'b1; in0 = 32'hFFFF_FFFF; in1 = 32'd2; push(32'd1, 1'b1);
    tick();
    in_valid = 1'b0; op = 1'b0; in0 = 32'd9; in1 = 32'd9;
    tick();
    check("valid_low_after", 64'(valid_q), 64'd0);
    check("res_hold", 64'(res_q), 64'd1);
    check("carry_hold", 64'(carry_q), 64'd1);
    tick();
    check("res_hold2", 64'(res_q), 64'd1);
    check("sb_drain1", 64'(sb.size()), 64'd0);

    // Async reset between edges after capturing 48.
    op = 1'b0; in0 = 32'd3; in1 = 32'd4; in_valid = 1'b1; push(32'd48, 1'b0);
    tick();
    in0 = 32'd1; in1 = 32'd1;
    #6;  // past the negedge, before the next posedge
    check("pre_rst_res", 64'(res_q), 64'd48);
    rst = 1'b0; #1;
    check("async_res_q", 64'(res_q), 64'd0);
    check("async_valid_q", 64'(valid_q), 64'd0);
    check("async_carry_q", 64'(carry_q), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      in0 = 32'(i + 2); in1 = 32'(i + 1); #1;
      check("rst_hold_valid", 64'(valid_q), 64'd0);
      check("rst_hold_res", 64'(res_q), 64'd0);
      check("rst_out_track", 64'(out), 64'((i + 2) << (i + 1)));
    end
    // Release between edges with in_valid still high: next edge captures.
    #3;
    rst = 1'b1;
    in0 = 32'd5; in1 = 32'd3; push(32'd40, 1'b0);
    tick();
    check("post_rst_valid", 64'(valid_q), 64'd1);
    in_valid = 1'b0;
    tick();
    tick();
    check("sb_drain2", 64'(sb.size()), 64'd0);

    // WIDTH=8 instance.
    a8 = 8'h81; b8 = 8'd1; #1;
    check("w8_shl", 64'(out8), 64'h02);
    b8 = 8'd8; #1;
    check("w8_shl_oob", 64'(out8), 64'd0);
    b8 = 8'd7; #1;
    check("w8_shl_7", 64'(out8), 64'h80);
    a8 = 8'hF0; b8 = 8'h20; #1;
    check("w8_sum", 64'(sum8), 64'h10);
    check("w8_cout", 64'(cout8), 64'd1);
    check("w8_valid_idle", 64'(valid8), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
